v188_mem_arbiter: RTL and testbench
===================================

// Module: v188_mem_arbiter
// PURPOSE
//   Two-port arbiter that shares the V188 external 8-bit memory bus (20-bit address, rd/wr strobes, ready)
//   between the CPU bus unit (port C) and a DMA engine (port D). Sits between the V188 core and the
//   board-level memory pins; serialises single-byte transfers, applies round-robin or fixed priority,
//   and aborts transfers when ready never arrives.
// PARAMETERS
//   AW            20   address width
//   DW            8    data width
//   TIMEOUT       255  max ACCESS cycles waiting for ready before abort; 0 = wait forever
//   CPU_FIXED_PRI 0    1 = CPU wins every tie; 0 = round-robin
// PORTS
//   clk       in   1   single clock, all logic on posedge
//   reset_n   in   1   asynchronous active-low reset
//   c_req     in   1   CPU request, level, held until c_ack
//   c_wr      in   1   CPU: 1 = write, 0 = read
//   c_addr    in   AW  CPU address
//   c_wdata   in   DW  CPU write data
//   c_ack     out  1   CPU transfer complete, 1-cycle pulse
//   c_err     out  1   valid with c_ack: transfer timed out
//   c_rdata   out  DW  CPU read data, valid from c_ack, held until next CPU read completes
//   d_req/d_wr/d_addr/d_wdata/d_ack/d_err/d_rdata   same as above, DMA port
//   a         out  AW  memory address
//   dout      out  DW  memory write data
//   mrdout    out  1   memory read strobe
//   mwrout    out  1   memory write strobe
//   ready     in   1   memory ready, sampled only in ACCESS
//   din       in   DW  memory read data, sampled on the edge where ready=1
//   owner     out  1   0 = CPU, 1 = DMA; valid while busy
//   busy      out  1   1 in ACCESS and ACK
// BEHAVIOUR
//   Reset (async): state=IDLE, strobes/acks/errs/busy=0, a=0, dout=0, rdata=0, owner=0, rr_last=DMA.
//   All outputs are registered. Reset mid-transfer drops strobes immediately; no ack is issued.
//   FSM IDLE -> ACCESS -> ACK -> IDLE:
//   - IDLE: if any req at edge N, select winner, latch its addr/wdata/wr into a/dout, set owner,
//     raise mrdout or mwrout, clear wait counter, go to ACCESS (strobe visible in cycle N+1).
//     Tie: CPU_FIXED_PRI=1 -> CPU wins; otherwise the port not served last wins (CPU wins first tie).
//     A lone requester is always granted, whatever rr_last is.
//   - ACCESS: a/dout/strobe held stable. On an edge with ready=1: drop strobe; for reads capture
//     din into the owner's rdata; raise owner's ack (err=0); go to ACK.
//     Otherwise the counter increments; if TIMEOUT!=0 and counter==TIMEOUT-1: drop strobe,
//     raise ack with err=1, set rdata=all-ones for reads, go to ACK.
//   - ACK: ack/err high exactly this cycle; requests are ignored (turnaround). rr_last<=owner. -> IDLE.
//   Requesters drop req in the ack cycle, or keep it high to queue the next transfer (sampled in IDLE).
//   Minimum latency: req sampled at edge N, strobe N+1, ack N+2 (ready on first ACCESS edge),
//   next grant at N+3. Peak throughput: 1 transfer per 3 cycles.
//   ready is ignored in IDLE and ACK. Address/data changes on a requester port while it is waiting or
//   being served have no effect; values latched at grant are used.
//   A write leaves that port's rdata unchanged. The non-owner's ack/err/rdata never change.
//   Wait counter width: clog2(TIMEOUT+1), saturating; with TIMEOUT=0 it is unused.
// STRUCTURE
//   Package v188_bus_pkg: arb_state_t {IDLE, ACCESS, ACK}, owner_t {OWN_CPU, OWN_DMA},
//   localparams V188_AW=20, V188_DW=8.
//   Sub-module v188_wait_timer: clear/enable/terminal-count counter for the ready timeout.
//   Winner select is inline combinational logic; FSM and output registers sit in one always block.
// TESTING
//   CPU read 0x12345, ready on first ACCESS edge, din=0xA5 -> mrdout high 1 cycle, c_ack at N+2,
//     c_rdata=0xA5, c_err=0.
//   c_req and d_req held high together for 4 transfers, ready tied 1 -> grants C,D,C,D; each ack 1 cycle.
//   Same stimulus with CPU_FIXED_PRI=1 -> all 4 grants CPU while c_req stays high; D served after C drops.
//   DMA write 0xFFFFF/0x3C with ready delayed 5 cycles -> a/dout/mwrout stable 6 cycles, d_ack then,
//     d_rdata unchanged.
//   TIMEOUT=8, CPU read, ready held 0 -> c_ack with c_err=1 after 8 ACCESS cycles, c_rdata=0xFF.
//   reset_n pulsed low during ACCESS -> strobes low asynchronously, no ack; after release a new
//     request completes normally.

Source files
------------

// File: rtl/v188_bus_pkg.sv
// Shared types and constants for the V188 external memory bus arbiter.
package v188_bus_pkg;
    localparam int V188_AW = 20;
    localparam int V188_DW = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} arb_state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

    // Wait-counter width; a zero timeout still gets a minimal 1-bit counter.
    function automatic int cntWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/v188_wait_timer.sv
// Saturating wait counter for the ready timeout; expired flags the last allowed ACCESS cycle.
module v188_wait_timer
    import v188_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = cntWidth(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (int'(count) == TIMEOUT - 1);
endmodule

// File: rtl/v188_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for the V188 8-bit external memory bus: one registered
// single-byte transfer at a time, round-robin or fixed CPU priority, ready timeout abort.
module v188_mem_arbiter
    import v188_bus_pkg::*;
#(
    parameter int AW            = V188_AW,
    parameter int DW            = V188_DW,
    parameter int TIMEOUT       = 255,
    parameter int CPU_FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] a,
    output logic [DW-1:0] dout,
    output logic          mrdout,
    output logic          mwrout,
    input  logic          ready,
    input  logic [DW-1:0] din,
    output logic          owner,
    output logic          busy
);
    arb_state_t    state;
    owner_t        rrLast;
    logic          grantDma;
    logic          selWr;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic          tmrExpired;
    logic          done;

    // DMA wins only alone, or on a round-robin tie when the CPU was served last.
    always_comb begin
        grantDma = d_req && (!c_req || (CPU_FIXED_PRI == 0 && rrLast == OWN_CPU));
        selWr    = grantDma ? d_wr    : c_wr;
        selAddr  = grantDma ? d_addr  : c_addr;
        selWdata = grantDma ? d_wdata : c_wdata;
        done     = ready || tmrExpired;
    end

    v188_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .enable  (state == ACCESS && !ready),
        .expired (tmrExpired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rrLast  <= OWN_DMA;
            a       <= '0;
            dout    <= '0;
            mrdout  <= 1'b0;
            mwrout  <= 1'b0;
            owner   <= 1'b0;
            busy    <= 1'b0;
            c_ack   <= 1'b0;
            c_err   <= 1'b0;
            c_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end else begin
            c_ack <= 1'b0;
            c_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        a      <= selAddr;
                        dout   <= selWdata;
                        owner  <= grantDma;
                        mwrout <= selWr;
                        mrdout <= !selWr;
                        busy   <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        mrdout <= 1'b0;
                        mwrout <= 1'b0;
                        state  <= ACK;
                        // Ready takes precedence over a coincident timeout.
                        if (owner) begin
                            d_ack <= 1'b1;
                            d_err <= !ready;
                            if (mrdout) d_rdata <= ready ? din : '1;
                        end else begin
                            c_ack <= 1'b1;
                            c_err <= !ready;
                            if (mrdout) c_rdata <= ready ? din : '1;
                        end
                    end
                end
                ACK: begin
                    busy   <= 1'b0;
                    rrLast <= owner ? OWN_DMA : OWN_CPU;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v188_mem_arbiter.sv
// Directed scoreboard bench: dut0 is round-robin with TIMEOUT=8, dut1 is fixed CPU priority
// with the default timeout; both share inputs and are reset between phases.
module tb_v188_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c_req = 1'b0, c_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [19:0] c_addr = '0, d_addr = '0;
    logic [7:0]  c_wdata = '0, d_wdata = '0, din = '0;
    logic        ready = 1'b0;

    logic        cAck[2], cErr[2], dAck[2], dErr[2], mrd[2], mwr[2], own[2], bsy[2];
    logic [7:0]  cRd[2], dRd[2], dout[2];
    logic [19:0] addr[2];

    typedef struct {
        logic        own;
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        err;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] expCRd = '0, expDRd = '0;
    int         total = 0, bad = 0;
    int         lat, strobes, acks;

    always #5 clk = ~clk;

    v188_mem_arbiter #(.TIMEOUT(8), .CPU_FIXED_PRI(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(cAck[0]), .c_err(cErr[0]), .c_rdata(cRd[0]),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(dAck[0]), .d_err(dErr[0]), .d_rdata(dRd[0]),
        .a(addr[0]), .dout(dout[0]), .mrdout(mrd[0]), .mwrout(mwr[0]),
        .ready(ready), .din(din), .owner(own[0]), .busy(bsy[0])
    );

    v188_mem_arbiter #(.TIMEOUT(255), .CPU_FIXED_PRI(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(cAck[1]), .c_err(cErr[1]), .c_rdata(cRd[1]),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(dAck[1]), .d_err(dErr[1]), .d_rdata(dRd[1]),
        .a(addr[1]), .dout(dout[1]), .mrdout(mrd[1]), .mwrout(mwr[1]),
        .ready(ready), .din(din), .owner(own[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        c_req = 1'b0;
        d_req = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expQ.delete();
        expCRd = '0;
        expDRd = '0;
    endtask

    // Expected rdata follows a per-port model: reads load din (or all-ones on abort), writes keep it.
    task automatic pushExp(input logic o, input logic w, input logic [19:0] ad,
                           input logic [7:0] wd, input logic er, input logic [7:0] rdin);
        exp_t e;
        if (!w) begin
            if (o) expDRd = er ? 8'hFF : rdin;
            else   expCRd = er ? 8'hFF : rdin;
        end
        e.own = o; e.wr = w; e.addr = ad; e.wdata = wd; e.err = er;
        e.rdata = o ? expDRd : expCRd;
        expQ.push_back(e);
    endtask

    task automatic runXfer(input int s, input int readyAt, input bit dropC, input bit dropD,
                           input bit scramble, output int latency, output int nStrobe);
        exp_t        e;
        bit          got = 0, unstable = 0;
        logic [19:0] sa = 'x;
        logic [7:0]  sd = 'x;
        logic        sw = 1'bx, so = 1'bx;
        latency = 0;
        nStrobe = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (mrd[s] | mwr[s]) begin
                if (nStrobe == 0) begin
                    sa = addr[s]; sd = dout[s]; sw = mwr[s]; so = own[s];
                end else if (addr[s] !== sa || dout[s] !== sd || mwr[s] !== sw) begin
                    unstable = 1;
                end
                nStrobe++;
                if (scramble && nStrobe == 1) begin
                    c_addr = ~c_addr; d_addr = ~d_addr; c_wdata = ~c_wdata; d_wdata = ~d_wdata;
                end
                if (readyAt != 0 && nStrobe == readyAt) ready = 1'b1;
            end
            if (cAck[s] | dAck[s]) begin
                got = 1;
                latency = i;
                if (dropC) c_req = 1'b0;
                if (dropD) d_req = 1'b0;
            end
        end
        chk("ack_seen", 32'(got), 1);
        if (!got) return;
        chk("sb_nonempty", 32'(expQ.size() != 0), 1);
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        chk("grant_owner", so, e.own);
        chk("owner_out", own[s], e.own);
        chk("strobe_kind", sw, e.wr);
        chk("addr", sa, e.addr);
        if (e.wr) chk("dout", sd, e.wdata);
        chk("strobe_stable", 32'(unstable), 0);
        chk("c_ack", cAck[s], !e.own);
        chk("d_ack", dAck[s], e.own);
        chk("err", e.own ? dErr[s] : cErr[s], e.err);
        chk("other_err", e.own ? cErr[s] : dErr[s], 0);
        chk("rdata", e.own ? dRd[s] : cRd[s], e.rdata);
        chk("other_rdata", e.own ? cRd[s] : dRd[s], e.own ? expCRd : expDRd);
        chk("strobe_off", mrd[s] | mwr[s], 0);
        @(negedge clk);
        chk("ack_pulse", cAck[s] | dAck[s], 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_addr", addr[0], 0);
        chk("rst_dout", dout[0], 0);
        chk("rst_strobes", {mrd[0], mwr[0]}, 0);
        chk("rst_acks", {cAck[0], cErr[0], dAck[0], dErr[0]}, 0);
        chk("rst_owner_busy", {own[0], bsy[0]}, 0);
        chk("rst_rdata", {cRd[0], dRd[0]}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // CPU read, minimum latency
        ready = 1'b1; din = 8'hA5;
        c_wr = 1'b0; c_addr = 20'h12345; c_req = 1'b1;
        pushExp(1'b0, 1'b0, 20'h12345, 8'h00, 1'b0, 8'hA5);
        runXfer(0, 0, 1, 0, 0, lat, strobes);
        chk("min_latency", lat, 2);
        chk("min_strobes", strobes, 1);
        chk("busy_after", bsy[0], 0);

        // Round-robin tie on dut0: C, D, C, D
        doReset();
        ready = 1'b1;
        c_wr = 1'b0; c_addr = 20'h00100;
        d_wr = 1'b0; d_addr = 20'h00200;
        c_req = 1'b1; d_req = 1'b1;
        din = 8'h11; pushExp(1'b0, 1'b0, 20'h00100, 8'h00, 1'b0, 8'h11);
        runXfer(0, 0, 0, 0, 0, lat, strobes);
        c_wr = 1'b1; c_addr = 20'h00101; c_wdata = 8'h33;
        din = 8'h22; pushExp(1'b1, 1'b0, 20'h00200, 8'h00, 1'b0, 8'h22);
        runXfer(0, 0, 0, 0, 0, lat, strobes);
        d_wr = 1'b1; d_addr = 20'h00201; d_wdata = 8'h44;
        din = 8'h5E; pushExp(1'b0, 1'b1, 20'h00101, 8'h33, 1'b0, 8'h00);
        runXfer(0, 0, 0, 0, 0, lat, strobes);
        pushExp(1'b1, 1'b1, 20'h00201, 8'h44, 1'b0, 8'h00);
        runXfer(0, 0, 1, 1, 0, lat, strobes);

        // Fixed CPU priority on dut1: CPU x4, then DMA once CPU drops
        doReset();
        ready = 1'b1;
        c_wr = 1'b0; c_addr = 20'h0A000;
        d_wr = 1'b1; d_addr = 20'h0B000; d_wdata = 8'h77;
        c_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din = 8'(k);
            pushExp(1'b0, 1'b0, 20'h0A000, 8'h00, 1'b0, 8'(k));
            runXfer(1, 0, k == 4, 0, 0, lat, strobes);
        end
        pushExp(1'b1, 1'b1, 20'h0B000, 8'h77, 1'b0, 8'h00);
        runXfer(1, 0, 0, 1, 0, lat, strobes);

        // DMA write at top address, ready after 5 wait cycles, inputs changed mid-transfer
        doReset();
        din = 8'h99;
        d_wr = 1'b1; d_addr = 20'hFFFFF; d_wdata = 8'h3C; d_req = 1'b1;
        pushExp(1'b1, 1'b1, 20'hFFFFF, 8'h3C, 1'b0, 8'h00);
        runXfer(0, 6, 0, 1, 1, lat, strobes);
        chk("delay_strobes", strobes, 6);
        chk("delay_latency", lat, 7);

        // Timeout abort on dut0 (TIMEOUT=8)
        doReset();
        din = 8'h12;
        c_wr = 1'b0; c_addr = 20'h00042; c_req = 1'b1;
        pushExp(1'b0, 1'b0, 20'h00042, 8'h00, 1'b1, 8'h00);
        runXfer(0, 0, 1, 0, 0, lat, strobes);
        chk("tmo_strobes", strobes, 8);
        chk("tmo_latency", lat, 9);

        // Reset during ACCESS: strobes drop at once, no ack, then a normal transfer
        doReset();
        c_wr = 1'b0; c_addr = 20'h00777; c_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_strobe", mrd[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_strobe", {mrd[0], mwr[0]}, 0);
        chk("async_busy", bsy[0], 0);
        c_req = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            acks += int'(cAck[0]) + int'(dAck[0]);
        end
        chk("no_ack_in_reset", acks, 0);
        reset_n = 1'b1;
        expQ.delete();
        ready = 1'b1; din = 8'hC3; c_req = 1'b1;
        pushExp(1'b0, 1'b0, 20'h00777, 8'h00, 1'b0, 8'hC3);
        runXfer(0, 0, 1, 0, 0, lat, strobes);
        chk("post_rst_latency", lat, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
